// File: rtl/cam_dma_rd_pkg.sv
// Shared types and constants for the camera DMA frame reader: FSM states,
// the 32-bit pixel slot carried in each half of a DMA word, and RGB888 offsets.
package cam_dma_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_STREAM = 2'd2,
    ST_FLUSH  = 2'd3
  } rd_state_e;

  localparam int PIX_SLOT_W = 32;
  localparam int WORD_W     = 2 * PIX_SLOT_W;
  localparam int RGB_W      = 24;
  localparam int B_OFF      = 0;
  localparam int G_OFF      = 8;
  localparam int R_OFF      = 16;

endpackage

// File: rtl/cam_dma_rd_unpack.sv
// Holds one 64-bit DMA word and presents its two pixels, pixel0 then pixel1,
// on a valid/ready port; accepts a new word in the cycle the old one empties.
module cam_dma_rd_unpack
  import cam_dma_rd_pkg::*;
(
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [RGB_W-1:0]  out_data_o,
  output logic              out_empty_o
);

  logic             hold_valid_q, hold_valid_d;
  logic             sel_q, sel_d;
  logic [RGB_W-1:0] pix0_q, pix0_d;
  logic [RGB_W-1:0] pix1_q, pix1_d;
  logic             out_fire;
  logic             load;

  // Only the RGB888 part of each slot is kept; the top byte of each slot is dropped.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{in_data_i[PIX_SLOT_W-1:RGB_W], in_data_i[WORD_W-1:PIX_SLOT_W+RGB_W]};

  assign out_valid_o = hold_valid_q;
  assign out_data_o  = sel_q ? pix1_q : pix0_q;
  assign out_fire    = hold_valid_q & out_ready_i;
  assign out_empty_o = out_fire & sel_q;
  assign in_ready_o  = ~hold_valid_q | out_empty_o;
  assign load        = in_valid_i & in_ready_o;

  always_comb begin
    hold_valid_d = hold_valid_q;
    sel_d        = sel_q;
    pix0_d       = pix0_q;
    pix1_d       = pix1_q;
    if (load) begin
      hold_valid_d = 1'b1;
      sel_d        = 1'b0;
      pix0_d       = in_data_i[B_OFF +: RGB_W];
      pix1_d       = in_data_i[PIX_SLOT_W + B_OFF +: RGB_W];
    end else if (out_empty_o) begin
      hold_valid_d = 1'b0;
      sel_d        = 1'b0;
    end else if (out_fire) begin
      sel_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      hold_valid_q <= 1'b0;
      sel_q        <= 1'b0;
      pix0_q       <= '0;
      pix1_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      sel_q        <= sel_d;
      pix0_q       <= pix0_d;
      pix1_q       <= pix1_d;
    end
  end

endmodule

// File: rtl/cam_dma_frame_reader.sv
// Reads one camera frame per arming from a DMA read stream and emits it as a
// pixel stream with start/end-of-line/end-of-frame flags and length checking.
module cam_dma_frame_reader
  import cam_dma_rd_pkg::*;
#(
  parameter int FRAME_WIDTH         = 1280,
  parameter int FRAME_HEIGHT        = 720,
  parameter int DMA_TRANSFER_LENGTH = (FRAME_WIDTH * FRAME_HEIGHT) / 2
) (
  input  logic              io_peripheralClk,
  input  logic              io_peripheralReset,
  input  logic              trigger_read_frame,
  input  logic              continuous_read_frame,
  input  logic              dma_init_done,
  input  logic              cam_dma_rvalid,
  output logic              cam_dma_rready,
  input  logic              cam_dma_rlast,
  input  logic [WORD_W-1:0] cam_dma_rdata,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [RGB_W-1:0]  px_data,
  output logic              px_sof,
  output logic              px_eol,
  output logic              px_eof,
  output logic              frame_busy,
  output logic              err_short,
  output logic              err_long,
  output logic [15:0]       frames_done
);

  localparam int XW  = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int YW  = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int WCW = (DMA_TRANSFER_LENGTH > 1) ? $clog2(DMA_TRANSFER_LENGTH) : 1;
  localparam logic [XW-1:0]  X_LAST  = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(FRAME_HEIGHT - 1);
  localparam logic [WCW-1:0] WC_LAST = WCW'(DMA_TRANSFER_LENGTH - 1);

  rd_state_e      state_q, state_d;
  logic           trig_q;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [WCW-1:0] wc_q, wc_d;
  logic           last_acc_q, last_acc_d;
  logic           err_short_q, err_short_d;
  logic           err_long_q, err_long_d;
  logic [15:0]    frames_done_q, frames_done_d;

  logic up_in_ready;
  logic up_in_valid;
  logic up_empty;
  logic accept_en;
  logic word_acc;
  logic px_fire;
  logic trig_edge;

  // Words are taken only in STREAM and only until the frame's last word is in hand.
  assign accept_en   = (state_q == ST_STREAM) & ~last_acc_q;
  assign up_in_valid = cam_dma_rvalid & accept_en;
  assign word_acc    = up_in_valid & up_in_ready;
  assign px_fire     = px_valid & px_ready;
  assign trig_edge   = trigger_read_frame & ~trig_q;

  cam_dma_rd_unpack u_unpack (
    .clk_i       (io_peripheralClk),
    .srst_i      (io_peripheralReset),
    .in_valid_i  (up_in_valid),
    .in_ready_o  (up_in_ready),
    .in_data_i   (cam_dma_rdata),
    .out_valid_o (px_valid),
    .out_ready_i (px_ready),
    .out_data_o  (px_data),
    .out_empty_o (up_empty)
  );

  assign cam_dma_rready = (accept_en & up_in_ready) | (state_q == ST_FLUSH);
  assign px_sof         = px_valid & (x_q == '0) & (y_q == '0);
  assign px_eol         = px_valid & (x_q == X_LAST);
  assign px_eof         = px_valid & (x_q == X_LAST) & (y_q == Y_LAST);
  assign frame_busy     = (state_q == ST_ARM) | (state_q == ST_STREAM);
  assign err_short      = err_short_q;
  assign err_long       = err_long_q;
  assign frames_done    = frames_done_q;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    wc_d          = wc_q;
    last_acc_d    = last_acc_q;
    err_short_d   = err_short_q;
    err_long_d    = err_long_q;
    frames_done_d = frames_done_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trig_edge | continuous_read_frame) begin
          state_d     = ST_ARM;
          x_d         = '0;
          y_d         = '0;
          wc_d        = '0;
          last_acc_d  = 1'b0;
          err_short_d = 1'b0;
          err_long_d  = 1'b0;
        end
      end
      ST_ARM: begin
        if (dma_init_done) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (word_acc) begin
          if (wc_q == WC_LAST) begin
            last_acc_d = 1'b1;
            if (!cam_dma_rlast) err_long_d = 1'b1;
          end else if (cam_dma_rlast) begin
            last_acc_d  = 1'b1;
            err_short_d = 1'b1;
          end else begin
            wc_d = wc_q + 1'b1;
          end
        end
        if (px_fire) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
        // The frame ends when pixel1 of the last accepted word leaves.
        if (up_empty && last_acc_q) begin
          state_d = err_long_q ? ST_FLUSH : ST_IDLE;
          if (!err_long_q && !err_short_q) frames_done_d = frames_done_q + 16'd1;
        end
      end
      ST_FLUSH: begin
        if (cam_dma_rvalid && cam_dma_rlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge io_peripheralClk) begin
    if (io_peripheralReset) begin
      state_q       <= ST_IDLE;
      trig_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      wc_q          <= '0;
      last_acc_q    <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      trig_q        <= trigger_read_frame;
      x_q           <= x_d;
      y_q           <= y_d;
      wc_q          <= wc_d;
      last_acc_q    <= last_acc_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
      frames_done_q <= frames_done_d;
    end
  end

endmodule

// File: tb/tb_cam_dma_frame_reader.sv
// Directed bench for cam_dma_frame_reader with a 4x2 frame: expected pixels are
// queued as DMA words are offered and compared as the pixel port hands them over.
module tb_cam_dma_frame_reader;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int LEN = 4;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        trig = 1'b0;
  logic        cont = 1'b0;
  logic        init = 1'b0;
  logic        rvalid = 1'b0;
  logic        rlast = 1'b0;
  logic [63:0] rdata = '0;
  logic        px_ready = 1'b1;
  logic        rready, px_valid, sof, eol, eof, busy, errs, errl;
  logic [23:0] px_data;
  logic [15:0] frames_done;

  typedef struct packed {
    logic [23:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  logic [26:0] prev;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   obs_cnt = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  int   word_no = 0;
  bit   bp_mode = 1'b0;
  bit   stalled = 1'b0;

  cam_dma_frame_reader #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .DMA_TRANSFER_LENGTH(LEN)
  ) dut (
    .io_peripheralClk      (clk),
    .io_peripheralReset    (srst),
    .trigger_read_frame    (trig),
    .continuous_read_frame (cont),
    .dma_init_done         (init),
    .cam_dma_rvalid        (rvalid),
    .cam_dma_rready        (rready),
    .cam_dma_rlast         (rlast),
    .cam_dma_rdata         (rdata),
    .px_valid              (px_valid),
    .px_ready              (px_ready),
    .px_data               (px_data),
    .px_sof                (sof),
    .px_eol                (eol),
    .px_eof                (eof),
    .frame_busy            (busy),
    .err_short             (errs),
    .err_long              (errl),
    .frames_done           (frames_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    px_ready = bp_mode ? ~px_ready : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pix_t mk(input logic [23:0] d, input int p);
    pix_t r;
    r.d   = d;
    r.sof = (p == 0);
    r.eol = ((p % W) == W - 1);
    r.eof = (p == W * H - 1);
    return r;
  endfunction

  task automatic send_word(input int widx, input logic [63:0] data, input bit last, input bit push);
    bit got;
    got = 1'b0;
    if (push) begin
      exp_q.push_back(mk(data[23:0], 2 * widx));
      exp_q.push_back(mk(data[55:32], 2 * widx + 1));
    end
    rvalid = 1'b1;
    rdata  = data;
    rlast  = last;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (rready) got = 1'b1;
    end
    @(posedge clk); #1;
    check("dma_accept", 64'(got), 64'd1);
    $display("word %0d data=%h last=%0b accepted=%0b", word_no, data, last, got);
    word_no++;
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic send_frame(input int nwords, input int last_at, input int npush);
    for (int w = 0; w < nwords; w++)
      send_word(w, {$urandom, $urandom}, w == last_at, w < npush);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    @(posedge clk); #1 trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
  endtask

  // Pixel monitor: pops the scoreboard on every handshake and watches stalls.
  always @(negedge clk) begin
    if (srst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_hold_valid", 64'(px_valid), 64'd1);
        check("stall_hold_data", 64'({px_data, sof, eol, eof}), 64'(prev));
      end
      if (px_valid) begin
        if (px_ready) begin
          check("px_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("px_data", 64'(px_data), 64'(mon_e.d));
            check("px_flags", 64'({sof, eol, eof}), 64'({mon_e.sof, mon_e.eol, mon_e.eof}));
          end
          if (obs_cnt == 0) first_cyc = cyc;
          last_cyc = cyc;
          obs_cnt++;
          stalled = 1'b0;
        end else begin
          check("rready_when_full", 64'(rready), 64'd0);
          prev    = {px_data, sof, eol, eof};
          stalled = 1'b1;
        end
      end else begin
        check("flags_without_valid", 64'({sof, eol, eof}), 64'd0);
        stalled = 1'b0;
      end
    end
  end

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_px_valid", 64'(px_valid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_px_data", 64'(px_data), 64'd0);
    check("rst_busy_errs", 64'({busy, errs, errl}), 64'd0);
    check("rst_frames_done", 64'(frames_done), 64'd0);
    @(posedge clk); #1 srst = 1'b0;

    // Normal frame at full throughput.
    init = 1'b1;
    obs_cnt = 0;
    pulse_trigger();
    send_frame(4, 3, 4);
    wait_drain();
    check("normal_pixels", 64'(obs_cnt), 64'd8);
    check("normal_span", 64'(last_cyc - first_cyc), 64'd7);
    check("normal_frames_done", 64'(frames_done), 64'd1);
    check("normal_errs", 64'({errs, errl, busy}), 64'd0);

    // Backpressure on the pixel port.
    bp_mode = 1'b1;
    obs_cnt = 0;
    pulse_trigger();
    send_frame(4, 3, 4);
    wait_drain();
    bp_mode = 1'b0;
    check("bp_pixels", 64'(obs_cnt), 64'd8);
    check("bp_frames_done", 64'(frames_done), 64'd2);

    // Short frame: rlast on word 1.
    obs_cnt = 0;
    pulse_trigger();
    send_frame(2, 1, 2);
    wait_drain();
    check("short_pixels", 64'(obs_cnt), 64'd4);
    check("short_err_short", 64'(errs), 64'd1);
    check("short_err_long", 64'(errl), 64'd0);
    check("short_frames_done", 64'(frames_done), 64'd2);
    check("short_idle", 64'({busy, rready}), 64'd0);

    // Long frame: rlast on word 5, words 4-5 must vanish.
    obs_cnt = 0;
    pulse_trigger();
    send_frame(6, 5, 4);
    wait_drain();
    check("long_pixels", 64'(obs_cnt), 64'd8);
    check("long_err_long", 64'(errl), 64'd1);
    check("long_err_short_cleared", 64'(errs), 64'd0);
    check("long_frames_done", 64'(frames_done), 64'd2);
    check("long_idle", 64'({busy, rready}), 64'd0);

    // Continuous mode held in ARM, then three frames, stopping after the third.
    init = 1'b0;
    cont = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("arm_busy", 64'(busy), 64'd1);
      check("arm_rready", 64'(rready), 64'd0);
    end
    @(posedge clk); #1 init = 1'b1;
    obs_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 4; w++) begin
        send_word(w, {$urandom, $urandom}, w == 3, 1'b1);
        if (f == 2 && w == 0) cont = 1'b0;
      end
    end
    wait_drain();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("cont_pixels", 64'(obs_cnt), 64'd24);
    check("cont_frames_done", 64'(frames_done), 64'd5);
    check("cont_stopped", 64'({busy, rready}), 64'd0);

    // Reset while pixel 5 is on the port.
    obs_cnt = 0;
    pulse_trigger();
    send_frame(3, -1, 3);
    for (int n = 0; n < 300 && obs_cnt < 5; n++) @(negedge clk);
    check("reach_pixel5", 64'(obs_cnt >= 5), 64'd1);
    @(posedge clk); #1 srst = 1'b1;
    @(posedge clk); #1 exp_q.delete();
    @(negedge clk);
    check("midrst_px_valid", 64'(px_valid), 64'd0);
    check("midrst_rready", 64'(rready), 64'd0);
    check("midrst_frames_done", 64'(frames_done), 64'd0);
    check("midrst_busy_errs", 64'({busy, errs, errl}), 64'd0);
    @(posedge clk); #1 srst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_px_valid", 64'(px_valid), 64'd0);
    check("post_rst_errs", 64'({errs, errl, busy}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
